// File: rtl/dcim_host_pkg.sv
// dcim_host_pkg: FSM state encoding, default geometry and init-timeout constant for the DCIM host driver
package dcim_host_pkg;
  localparam int DCIM_DATA_WIDTH   = 8;
  localparam int DCIM_ADDR_COUNT   = 16;
  localparam int DCIM_ADDR_WIDTH   = 4;
  localparam int DCIM_FIFO_DEPTH   = 4;
  localparam int DCIM_INIT_TIMEOUT = 256;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_INIT,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } dcim_state_e;
endpackage

// File: rtl/dcim_result_fifo.sv
// dcim_result_fifo: first-word-fall-through result FIFO (power-of-2 depth)
// Ports: push_i/data_i write side, pop_i/valid_o/data_o read side, count_o occupancy.
module dcim_result_fifo #(
  parameter int MULT_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [MULT_WIDTH-1:0]         data_i,
  input  logic                          pop_i,
  output logic                          valid_o,
  output logic [MULT_WIDTH-1:0]         data_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [MULT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push_i && cnt_q != (PW+1)'(FIFO_DEPTH);
    do_pop  = pop_i && valid_o;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= data_i;
  assign valid_o = cnt_q != '0;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/dcim_host_driver.sv
// dcim_host_driver: sequences weight load, credit-limited activation issue and result drain for a DCIM multiplier macro
// Ports: start/num_ops job control; s_* operand stream in; pe_*/init_* macro drive and return; m_* result stream out; busy/done/timeout_err status.
module dcim_host_driver
  import dcim_host_pkg::*;
#(
  parameter int DATA_WIDTH = DCIM_DATA_WIDTH,
  parameter int ADDR_COUNT = DCIM_ADDR_COUNT,
  parameter int ADDR_WIDTH = DCIM_ADDR_WIDTH,
  parameter int MULT_WIDTH = 2 * DATA_WIDTH,
  parameter int FIFO_DEPTH = DCIM_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           num_ops,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  pe_ce,
  output logic                  init_enable,
  output logic [DATA_WIDTH-1:0] pe_data,
  input  logic [MULT_WIDTH-1:0] pe_result,
  input  logic                  pe_valid,
  input  logic                  init_done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [MULT_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(DCIM_INIT_TIMEOUT) + 1;
  dcim_state_e state_q, state_d;
  logic [15:0] num_ops_q, num_ops_d, issued_q, issued_d;
  logic [ADDR_WIDTH:0] load_cnt_q, load_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW:0] inflight_q, inflight_d, fifo_cnt;
  logic [CW+1:0] occupancy;
  logic timeout_q, timeout_d, init_en_q, init_en_d;
  logic [DATA_WIDTH-1:0] pe_data_q, pe_data_d;
  logic job_start, credit_ok, hs, issue, accept, init_expired;
  // Results still in the macro pipeline already own a FIFO slot, so they count against credit.
  assign occupancy = (CW+2)'(fifo_cnt) + (CW+2)'(inflight_q);
  always_comb begin
    job_start    = state_q == S_IDLE && start;
    credit_ok    = occupancy < (CW+2)'(FIFO_DEPTH);
    s_ready      = state_q == S_LOAD || (state_q == S_COMPUTE && credit_ok && issued_q < num_ops_q);
    hs           = s_valid && s_ready;
    issue        = hs && state_q == S_COMPUTE;
    accept       = pe_valid && (state_q == S_COMPUTE || state_q == S_DRAIN);
    init_expired = !init_done && tmr_q == TW'(DCIM_INIT_TIMEOUT - 1);
    num_ops_d    = job_start ? num_ops : num_ops_q;
    load_cnt_d   = job_start ? '0 : load_cnt_q + (ADDR_WIDTH+1)'(hs && state_q == S_LOAD);
    issued_d     = job_start ? '0 : issued_q + 16'(issue);
    inflight_d   = job_start ? '0 : inflight_q + (CW+1)'(issue) - (CW+1)'(accept);
    tmr_d        = state_q == S_WAIT_INIT ? tmr_q + TW'(1) : '0;
    timeout_d    = job_start ? 1'b0 : timeout_q || (state_q == S_WAIT_INIT && init_expired);
    init_en_d    = hs && state_q == S_LOAD;
    pe_data_d    = hs ? s_data : pe_data_q;
    state_d      = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_LOAD;
      S_LOAD:      if (hs && load_cnt_q == (ADDR_WIDTH+1)'(ADDR_COUNT - 1)) state_d = S_WAIT_INIT;
      S_WAIT_INIT: if (init_done) state_d = num_ops_q == '0 ? S_DONE : S_COMPUTE;
                   else if (init_expired) state_d = S_DONE;
      S_COMPUTE:   if (issue && issued_q == num_ops_q - 16'd1) state_d = S_DRAIN;
      S_DRAIN:     if (inflight_q == '0 && !m_valid) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_ops_q  <= '0;
      issued_q   <= '0;
      load_cnt_q <= '0;
      tmr_q      <= '0;
      inflight_q <= '0;
      timeout_q  <= 1'b0;
      init_en_q  <= 1'b0;
      pe_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      num_ops_q  <= num_ops_d;
      issued_q   <= issued_d;
      load_cnt_q <= load_cnt_d;
      tmr_q      <= tmr_d;
      inflight_q <= inflight_d;
      timeout_q  <= timeout_d;
      init_en_q  <= init_en_d;
      pe_data_q  <= pe_data_d;
    end
  end
  dcim_result_fifo #(
    .MULT_WIDTH (MULT_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (pe_result),
    .pop_i   (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .count_o (fifo_cnt)
  );
  assign pe_ce       = state_q != S_IDLE;
  assign busy        = state_q != S_IDLE;
  assign done        = state_q == S_DONE;
  assign timeout_err = timeout_q;
  assign init_enable = init_en_q;
  assign pe_data     = pe_data_q;
endmodule

// File: doc/dcim_host_driver.md
DCIM_HOST_DRIVER -- requirements
Module: dcim_host_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width.
REQ-002 SHALL have parameter ADDR_COUNT, default 16, weight words per load.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, log2(ADDR_COUNT).
REQ-004 SHALL have parameter MULT_WIDTH, default 2*DATA_WIDTH, result width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2).
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-009 SHALL have port: start  input  1  pulse; begins a job; sampled only in IDLE.
REQ-010 SHALL have port: num_ops  input  16  activations for the job; sampled with start.
REQ-011 SHALL have ports: s_valid  input  1; s_ready  output  1; s_data  input  DATA_WIDTH  operand stream, weights first, then activations.
REQ-012 SHALL have ports: pe_ce  output  1; init_enable  output  1; pe_data  output  DATA_WIDTH  drive toward the multiplier macro.
REQ-013 SHALL have ports: pe_result  input  MULT_WIDTH; pe_valid  input  1; init_done  input  1  from the macro.
REQ-014 SHALL have ports: m_valid  output  1; m_ready  input  1; m_data  output  MULT_WIDTH  result stream.
REQ-015 SHALL have ports: busy  output  1; done  output  1 (one-cycle pulse); timeout_err  output  1 (sticky until next start).

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> WAIT_INIT -> COMPUTE -> DRAIN -> DONE -> IDLE.
REQ-017 IDLE: start=1 latches num_ops and clears timeout_err; next state is LOAD. start outside IDLE is ignored.
REQ-018 LOAD: s_ready=1; each handshake (s_valid&s_ready) at cycle t makes init_enable=1 and pe_data=s_data at cycle t+1. After ADDR_COUNT beats, the next state is WAIT_INIT.
REQ-019 WAIT_INIT: s_ready=0; waits for init_done=1, then goes to COMPUTE. If init_done stays low for 256 cycles, timeout_err is set and the next state is DONE.
REQ-020 COMPUTE: s_ready = (credits>0) & (issued<num_ops), where credits = FIFO free slots minus in-flight ops. A handshake at cycle t drives pe_data=s_data at t+1, with init_enable=0; in-flight is then incremented.
REQ-021 In-flight SHALL decrement on each pe_valid=1. Simultaneous issue and pe_valid leave in-flight unchanged.
REQ-022 Each pe_valid=1 SHALL push pe_result into the FIFO. Credit accounting guarantees this push never sees a full FIFO.
REQ-023 After num_ops issues, the FSM goes to DRAIN. It leaves DRAIN for DONE when in-flight==0 and the FIFO is empty.
REQ-024 num_ops=0 SHALL skip COMPUTE and DRAIN (WAIT_INIT -> DONE).
REQ-025 DONE: done=1 for one cycle; next state is IDLE.
REQ-026 pe_valid outside COMPUTE/DRAIN SHALL be dropped and SHALL NOT change in-flight.
REQ-027 The FIFO SHALL output first-word-fall-through: m_valid = not empty; m_data = head; pop on m_valid&m_ready. Simultaneous push and pop on a full FIFO is not reachable.
REQ-028 pe_ce SHALL be 1 in every state except IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Load and issue counters SHALL wrap only via FSM reset at job start, never arithmetically.

Reset
REQ-031 With rst=1 at a rising edge, the FSM SHALL go to IDLE on that edge, from any state, including mid-LOAD and mid-COMPUTE.
REQ-032 On that edge, all counters and FIFO pointers SHALL clear.
REQ-033 Reset values: s_ready=0, pe_ce=0, init_enable=0, pe_data=0, m_valid=0, m_data=0, busy=0, done=0, timeout_err=0.

Structure
REQ-034 Package dcim_host_pkg SHALL hold the FSM state enum and the default widths/depths.
REQ-035 Package dcim_host_pkg SHALL hold the 256-cycle timeout constant.
REQ-036 The result FIFO SHALL be a sub-module named dcim_result_fifo, parameterized by MULT_WIDTH and FIFO_DEPTH.

Verification
REQ-037 Load: start, stream 16 bytes 0..15 -> init_enable high for exactly 16 cycles; pe_data equals 0..15 in order, each one cycle after its handshake.
REQ-038 Compute: macro model with 1-cycle latency and pe_result=w*a; num_ops=16, m_ready=1 -> 16 results in order, then one done pulse.
REQ-039 Backpressure: m_ready=0, num_ops=10 -> at most 4 issues, then s_ready=0; FIFO holds 4 entries. Releasing m_ready -> all 10 results, no loss.
REQ-040 Timeout: init_done held low -> timeout_err=1 and done pulse 256 cycles after LOAD ends; no compute issues.
REQ-041 Reset mid-COMPUTE after 5 issues -> next cycle busy=0, m_valid=0; a new job with num_ops=0 -> done with zero results.
